debug_loader_ctrl: RTL

- Debug-unit controller between the UART byte interface and the MIPS pipeline.
- Receives a program over UART: a one-byte instruction count, then 4 bytes per instruction, least-significant byte first. Writes each assembled word into instruction memory.
- Then takes a mode byte and runs the CPU in continue or step-to-step mode.
- Reports PC (4 bytes) and executed cycle count (1 byte) back through the UART transmitter.

---
 rtl/debug_loader_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/debug_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_loader_ctrl
// Purpose  : UART-driven debug controller for the MIPS pipeline. Loads a
//            program into instruction memory, runs the CPU in continue or
//            single-step mode and reports PC plus executed cycle count.
// Revision : 1.0 - initial release
// ============================================================================
module debug_loader_ctrl #(
  parameter int                     NB_DATA     = 32,
  parameter int                     N_BITS_DATA = 8,
  parameter int                     NB_ADDR     = 8,
  parameter logic [N_BITS_DATA-1:0] MODE_STEP   = 8'h0F,
  parameter logic [N_BITS_DATA-1:0] MODE_CONT   = 8'hF0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_BITS_DATA-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  input  logic                   tx_done_i,
  output logic                   tx_start_o,
  output logic [N_BITS_DATA-1:0] tx_data_o,
  input  logic [NB_DATA-1:0]     pc_i,
  input  logic                   halt_i,
  output logic                   imem_wr_en_o,
  output logic [NB_ADDR-1:0]     imem_addr_o,
  output logic [NB_DATA-1:0]     imem_data_o,
  output logic                   cpu_en_o,
  output logic                   busy_o
);

  localparam int BYTES_PER_WORD = NB_DATA / N_BITS_DATA;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam int RIDX_W         = $clog2(BYTES_PER_WORD + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_MODE = 3'd2,
    S_RUN       = 3'd3,
    S_STEP_WAIT = 3'd4,
    S_STEP_EXEC = 3'd5,
    S_SEND      = 3'd6
  } state_e;

  state_e                           state_q;
  logic [N_BITS_DATA-1:0]           n_q;
  logic [NB_ADDR-1:0]               word_cnt_q;
  logic [BIDX_W-1:0]                byte_idx_q;
  logic [NB_DATA-1:0]               word_q;
  logic [N_BITS_DATA-1:0]           cyc_q;
  logic [N_BITS_DATA-1:0]           cyc_snap_q;
  logic [NB_DATA-1:0]               pc_snap_q;
  logic [RIDX_W-1:0]                rpt_idx_q;
  logic                             send_first_q;
  logic                             final_q;
  logic                             step_rpt_q;

  logic [NB_DATA-1:0]               w_word;
  logic [RIDX_W-1:0]                w_rpt_next;
  logic [NB_DATA+N_BITS_DATA-1:0]   w_report;
  logic [N_BITS_DATA-1:0]           w_tx_next;

  // Merge the incoming byte into the partially assembled word at its lane.
  always_comb begin
    w_word = (word_q & ~(NB_DATA'({N_BITS_DATA{1'b1}}) << (int'(byte_idx_q) * N_BITS_DATA)))
           | (NB_DATA'(rx_data_i) << (int'(byte_idx_q) * N_BITS_DATA));
  end

  // Pick the next report byte: PC bytes LSB first, cycle count last.
  always_comb begin
    w_rpt_next = rpt_idx_q + RIDX_W'(1);
    w_report   = {cyc_snap_q, pc_snap_q};
    w_tx_next  = N_BITS_DATA'(w_report >> (int'(w_rpt_next) * N_BITS_DATA));
  end

  // Main controller: state, counters and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      cyc_q        <= '0;
      cyc_snap_q   <= '0;
      pc_snap_q    <= '0;
      rpt_idx_q    <= '0;
      send_first_q <= 1'b0;
      final_q      <= 1'b0;
      step_rpt_q   <= 1'b0;
      tx_start_o   <= 1'b0;
      tx_data_o    <= '0;
      imem_wr_en_o <= 1'b0;
      imem_addr_o  <= '0;
      imem_data_o  <= '0;
      cpu_en_o     <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      tx_start_o   <= 1'b0;
      imem_wr_en_o <= 1'b0;

      // Executed-cycle counter saturates instead of wrapping.
      if (cpu_en_o && (cyc_q != '1)) begin
        cyc_q <= cyc_q + N_BITS_DATA'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (rx_valid_i && (rx_data_i != '0)) begin
            n_q        <= rx_data_i;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            cyc_q      <= '0;
            busy_o     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (rx_valid_i) begin
            word_q <= w_word;
            if (byte_idx_q == BIDX_W'(BYTES_PER_WORD - 1)) begin
              byte_idx_q   <= '0;
              imem_wr_en_o <= 1'b1;
              imem_addr_o  <= word_cnt_q;
              imem_data_o  <= w_word;
              word_cnt_q   <= word_cnt_q + NB_ADDR'(1);
              if (word_cnt_q == NB_ADDR'(n_q - N_BITS_DATA'(1))) begin
                state_q <= S_WAIT_MODE;
              end
            end else begin
              byte_idx_q <= byte_idx_q + BIDX_W'(1);
            end
          end
        end

        S_WAIT_MODE: begin
          if (rx_valid_i) begin
            if (rx_data_i == MODE_CONT) begin
              cpu_en_o <= 1'b1;
              state_q  <= S_RUN;
            end else if (rx_data_i == MODE_STEP) begin
              state_q <= S_STEP_WAIT;
            end
          end
        end

        S_RUN: begin
          if (halt_i) begin
            cpu_en_o     <= 1'b0;
            final_q      <= 1'b1;
            step_rpt_q   <= 1'b0;
            send_first_q <= 1'b1;
            state_q      <= S_SEND;
          end else begin
            cpu_en_o <= 1'b1;
          end
        end

        S_STEP_WAIT: begin
          // A CPU that has already halted gets its final report immediately.
          if (halt_i) begin
            final_q      <= 1'b1;
            step_rpt_q   <= 1'b0;
            send_first_q <= 1'b1;
            state_q      <= S_SEND;
          end else if (rx_valid_i) begin
            if (rx_data_i == MODE_STEP) begin
              cpu_en_o <= 1'b1;
              state_q  <= S_STEP_EXEC;
            end else if (rx_data_i == MODE_CONT) begin
              cpu_en_o <= 1'b1;
              state_q  <= S_RUN;
            end
          end
        end

        S_STEP_EXEC: begin
          cpu_en_o     <= 1'b0;
          step_rpt_q   <= 1'b1;
          send_first_q <= 1'b1;
          state_q      <= S_SEND;
        end

        S_SEND: begin
          if (send_first_q) begin
            // First SEND cycle: the CPU has settled after its last enable,
            // so PC, cycle count and halt status are sampled here.
            send_first_q <= 1'b0;
            pc_snap_q    <= pc_i;
            cyc_snap_q   <= cyc_q;
            if (step_rpt_q) begin
              final_q <= halt_i;
            end
            rpt_idx_q  <= '0;
            tx_data_o  <= pc_i[N_BITS_DATA-1:0];
            tx_start_o <= 1'b1;
          end else if (tx_done_i && !tx_start_o) begin
            if (rpt_idx_q == RIDX_W'(BYTES_PER_WORD)) begin
              rpt_idx_q <= '0;
              final_q   <= 1'b0;
              if (final_q) begin
                busy_o  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_STEP_WAIT;
              end
            end else begin
              rpt_idx_q  <= w_rpt_next;
              tx_data_o  <= w_tx_next;
              tx_start_o <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
